// File: rtl/stream_serializer_if.sv
// Stream serializer bus: N parallel input channels and one serialized output stream.
// The slave modport is the serializer's view; the master modport is the view of the
// environment, which feeds the input channels and consumes the output stream.
interface stream_serializer_if #(
   parameter int unsigned DW   = 24,
   parameter int unsigned N    = 4,
   parameter int unsigned TIDW = 8
);

   logic signed [DW-1:0]   s_axis_tdata [N];
   logic        [N-1:0]    s_axis_tvalid;
   logic        [N-1:0]    s_axis_tready;

   logic signed [DW-1:0]   m_axis_tdata;
   logic                   m_axis_tvalid;
   logic                   m_axis_tready;
   logic        [TIDW-1:0] m_axis_tid;
   logic                   m_axis_tlast;

   modport slave (
      input  s_axis_tdata,
      input  s_axis_tvalid,
      output s_axis_tready,
      output m_axis_tdata,
      output m_axis_tvalid,
      input  m_axis_tready,
      output m_axis_tid,
      output m_axis_tlast
   );

   modport master (
      output s_axis_tdata,
      output s_axis_tvalid,
      input  s_axis_tready,
      input  m_axis_tdata,
      input  m_axis_tvalid,
      output m_axis_tready,
      input  m_axis_tid,
      input  m_axis_tlast
   );

endinterface

// File: rtl/stream_serializer.sv
// Stream serializer: merges N independent sample channels into frames of N words,
// tid 0..N-1 in order with tlast on the final word. Each channel owns a one-word
// holding register; a round-robin pointer drains them strictly in channel order,
// stalling on an empty channel so frames are never reordered or emitted partially.
module stream_serializer #(
   parameter int unsigned DW   = 24,
   parameter int unsigned N    = 4,
   parameter int unsigned TIDW = 8
) (
   input  logic               clk,
   input  logic               rst,
   stream_serializer_if.slave bus
);

   localparam int unsigned   PW      = (N > 1) ? $clog2(N) : 1;
   localparam logic [PW-1:0] LastPtr = PW'(N - 1);

   // Per-channel holding registers
   logic signed [DW-1:0] hold_q [N];
   logic signed [DW-1:0] hold_d [N];
   logic        [N-1:0]  full_q;
   logic        [N-1:0]  full_d;
   logic        [N-1:0]  accept;

   // Round-robin pointer: next channel to emit
   logic [PW-1:0] ptr_q;
   logic [PW-1:0] ptr_d;

   // Registered output stage
   logic signed [DW-1:0]   data_q;
   logic signed [DW-1:0]   data_d;
   logic        [TIDW-1:0] tid_q;
   logic        [TIDW-1:0] tid_d;
   logic                   last_q;
   logic                   last_d;
   logic                   valid_q;
   logic                   valid_d;

   // Selected channel view and load control
   logic signed [DW-1:0] sel_data;
   logic                 sel_full;
   logic                 out_free;
   logic                 load;

   // Ready depends only on the holding register state, never on any tvalid.
   assign accept            = bus.s_axis_tvalid & ~full_q;
   assign bus.s_axis_tready = ~full_q;

   assign bus.m_axis_tdata  = data_q;
   assign bus.m_axis_tid    = tid_q;
   assign bus.m_axis_tlast  = last_q;
   assign bus.m_axis_tvalid = valid_q;

   // Select the channel under the pointer; explicit compare keeps non-power-of-2 N safe.
   always_comb begin
      sel_data = '0;
      sel_full = 1'b0;
      for (int unsigned i = 0; i < N; i++) begin
         if (ptr_q == PW'(i)) begin
            sel_data = hold_q[i];
            sel_full = full_q[i];
         end
      end
   end

   assign out_free = !valid_q || bus.m_axis_tready;
   assign load     = out_free && sel_full;

   // Holding register next state: capture on handshake, release on load.
   always_comb begin
      full_d = full_q;
      for (int unsigned i = 0; i < N; i++) begin
         hold_d[i] = hold_q[i];
         if (load && (ptr_q == PW'(i))) begin
            full_d[i] = 1'b0;
         end
         // Cannot coincide with a load of the same channel: ready is low while full.
         if (accept[i]) begin
            full_d[i] = 1'b1;
            hold_d[i] = bus.s_axis_tdata[i];
         end
      end
   end

   // Pointer advance with explicit wrap at N-1.
   always_comb begin
      ptr_d = ptr_q;
      if (load) begin
         ptr_d = (ptr_q == LastPtr) ? '0 : ptr_q + 1'b1;
      end
   end

   // Output stage next state: load a new word, or retire the accepted one.
   always_comb begin
      data_d  = data_q;
      tid_d   = tid_q;
      last_d  = last_q;
      valid_d = valid_q;
      if (load) begin
         data_d  = sel_data;
         tid_d   = TIDW'(ptr_q);
         last_d  = (ptr_q == LastPtr);
         valid_d = 1'b1;
      end else if (valid_q && bus.m_axis_tready) begin
         valid_d = 1'b0;
         last_d  = 1'b0;
      end
   end

   // Holding registers and occupancy flags.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         full_q <= '0;
         for (int unsigned i = 0; i < N; i++) begin
            hold_q[i] <= '0;
         end
      end else begin
         full_q <= full_d;
         for (int unsigned i = 0; i < N; i++) begin
            hold_q[i] <= hold_d[i];
         end
      end
   end

   // Round-robin pointer register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

   // Output register; an asynchronous reset drops any in-flight word at once.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_q  <= '0;
         tid_q   <= '0;
         last_q  <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         data_q  <= data_d;
         tid_q   <= tid_d;
         last_q  <= last_d;
         valid_q <= valid_d;
      end
   end

endmodule

// File: tb/tb_stream_serializer.sv
// Bench for stream_serializer: directed scenarios plus randomized traffic checked
// against a per-channel FIFO model with a frame-position counter.
module tb_stream_serializer;

   localparam int unsigned DW   = 24;
   localparam int unsigned N    = 4;
   localparam int unsigned N3   = 3;
   localparam int unsigned TIDW = 8;

   typedef logic signed [DW-1:0] word_t;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   stream_serializer_if #(.DW(DW), .N(N),  .TIDW(TIDW)) bus ();
   stream_serializer_if #(.DW(DW), .N(N3), .TIDW(TIDW)) bus3 ();

   stream_serializer #(.DW(DW), .N(N), .TIDW(TIDW)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   stream_serializer #(.DW(DW), .N(N3), .TIDW(TIDW)) u_dut3 (
      .clk (clk),
      .rst (rst),
      .bus (bus3)
   );

   int checks   = 0;
   int failures = 0;

   // Reference model: words accepted per channel, and observed output words.
   word_t          exp_q [N][$];
   word_t          obs_data [$];
   int             obs_tid [$];
   bit             obs_last [$];
   int             exp_tid;
   logic [N-1:0]   acc_last;

   function automatic word_t rand_word();
      case ($urandom_range(0, 7))
         0:       return word_t'(24'h800000);
         1:       return word_t'(24'h7fffff);
         2:       return word_t'(24'hffffff);
         default: return word_t'($urandom());
      endcase
   endfunction

   task automatic idle_inputs();
      bus.s_axis_tvalid  = '0;
      bus.m_axis_tready  = 1'b1;
      bus3.s_axis_tvalid = '0;
      bus3.m_axis_tready = 1'b1;
      for (int i = 0; i < N; i++) bus.s_axis_tdata[i] = '0;
      for (int i = 0; i < N3; i++) bus3.s_axis_tdata[i] = '0;
   endtask

   task automatic clear_model();
      for (int i = 0; i < N; i++) exp_q[i].delete();
      obs_data.delete();
      obs_tid.delete();
      obs_last.delete();
      exp_tid  = 0;
      acc_last = '0;
   endtask

   // One clock: sample handshakes at the falling edge, return just after the rising edge.
   task automatic cycle();
      @(negedge clk);
      acc_last = bus.s_axis_tvalid & bus.s_axis_tready;
      for (int i = 0; i < N; i++) begin
         if (acc_last[i]) exp_q[i].push_back(bus.s_axis_tdata[i]);
      end
      if (bus.m_axis_tvalid && bus.m_axis_tready) begin
         obs_data.push_back(bus.m_axis_tdata);
         obs_tid.push_back(int'(bus.m_axis_tid));
         obs_last.push_back(bus.m_axis_tlast);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      idle_inputs();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      clear_model();
   endtask

   task automatic test_reset();
      idle_inputs();
      rst = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if (bus.m_axis_tvalid !== 1'b0 || bus.m_axis_tlast !== 1'b0) begin
         failures++;
         $display("FAIL reset_valid_last got=%b/%b exp=0/0", bus.m_axis_tvalid, bus.m_axis_tlast);
      end
      checks++;
      if (bus.m_axis_tid !== '0 || bus.m_axis_tdata !== '0) begin
         failures++;
         $display("FAIL reset_tid_data got=%0d/%h exp=0/0", bus.m_axis_tid, bus.m_axis_tdata);
      end
      checks++;
      if (bus.s_axis_tready !== 4'b1111 || bus3.s_axis_tready !== 3'b111) begin
         failures++;
         $display("FAIL reset_tready got=%b/%b exp=1111/111", bus.s_axis_tready, bus3.s_axis_tready);
      end
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      clear_model();
   endtask

   task automatic test_basic();
      bus.m_axis_tready = 1'b1;
      for (int i = 0; i < N; i++) bus.s_axis_tdata[i] = word_t'(i + 1);
      bus.s_axis_tvalid = '1;
      cycle();
      bus.s_axis_tvalid = '0;
      checks++;
      if (bus.m_axis_tvalid !== 1'b0 || bus.s_axis_tready !== 4'b0000) begin
         failures++;
         $display("FAIL basic_capture got=valid %b ready %b exp=valid 0 ready 0000",
                  bus.m_axis_tvalid, bus.s_axis_tready);
      end
      for (int j = 0; j < N; j++) begin
         cycle();
         checks++;
         if (bus.m_axis_tvalid !== 1'b1 || bus.m_axis_tid !== TIDW'(j) ||
             bus.m_axis_tdata !== word_t'(j + 1) || bus.m_axis_tlast !== (j == N - 1)) begin
            failures++;
            $display("FAIL basic_word%0d got=v%b tid%0d d%h l%b exp=v1 tid%0d d%h l%b", j,
                     bus.m_axis_tvalid, bus.m_axis_tid, bus.m_axis_tdata, bus.m_axis_tlast,
                     j, word_t'(j + 1), (j == N - 1));
         end
      end
      cycle();
      checks++;
      if (bus.m_axis_tvalid !== 1'b0) begin
         failures++;
         $display("FAIL basic_idle got=%b exp=0", bus.m_axis_tvalid);
      end
      clear_model();
   endtask

   task automatic test_out_of_order();
      int order [4] = '{2, 0, 1, 3};
      int nwords = 0;
      bus.m_axis_tready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         bus.s_axis_tvalid = '0;
         bus.s_axis_tdata[order[k]] = rand_word();
         bus.s_axis_tvalid[order[k]] = 1'b1;
         cycle();
         checks++;
         if (bus.s_axis_tready[2] !== 1'b0) begin
            failures++;
            $display("FAIL ooo_ready2_step%0d got=%b exp=0", k, bus.s_axis_tready[2]);
         end
      end
      bus.s_axis_tvalid = '0;
      cycle();
      checks++;
      if (bus.s_axis_tready[2] !== 1'b1 || bus.m_axis_tid !== TIDW'(2)) begin
         failures++;
         $display("FAIL ooo_ready2_release got=ready %b tid %0d exp=ready 1 tid 2",
                  bus.s_axis_tready[2], bus.m_axis_tid);
      end
      repeat (3) cycle();
      while (obs_tid.size() > 0) begin
         int    t;
         bit    l;
         word_t d;
         word_t e;
         d = obs_data.pop_front();
         t = obs_tid.pop_front();
         l = obs_last.pop_front();
         e = (exp_q[exp_tid].size() > 0) ? exp_q[exp_tid].pop_front() : ~d;
         nwords++;
         checks++;
         if (t !== exp_tid || l !== (exp_tid == N - 1) || d !== e) begin
            failures++;
            $display("FAIL ooo_word got=tid%0d l%b d%h exp=tid%0d l%b d%h", t, l, d,
                     exp_tid, (exp_tid == N - 1), e);
         end
         exp_tid = (exp_tid + 1) % N;
      end
      checks++;
      if (nwords !== 4) begin
         failures++;
         $display("FAIL ooo_count got=%0d exp=4", nwords);
      end
   endtask

   task automatic test_backpressure();
      word_t d [N];
      int    nwords = 0;
      bus.m_axis_tready = 1'b0;
      for (int i = 0; i < N; i++) begin
         d[i] = rand_word();
         bus.s_axis_tdata[i] = d[i];
      end
      bus.s_axis_tvalid = '1;
      cycle();
      bus.s_axis_tvalid = '0;
      cycle();
      for (int k = 0; k < 5; k++) begin
         checks++;
         if (bus.m_axis_tvalid !== 1'b1 || bus.m_axis_tid !== '0 || bus.m_axis_tdata !== d[0] ||
             bus.m_axis_tlast !== 1'b0 || bus.s_axis_tready !== 4'b0001) begin
            failures++;
            $display("FAIL bp_stall%0d got=v%b tid%0d d%h l%b rdy%b exp=v1 tid0 d%h l0 rdy0001",
                     k, bus.m_axis_tvalid, bus.m_axis_tid, bus.m_axis_tdata, bus.m_axis_tlast,
                     bus.s_axis_tready, d[0]);
         end
         cycle();
      end
      bus.m_axis_tready = 1'b1;
      repeat (6) cycle();
      while (obs_tid.size() > 0) begin
         int    t;
         bit    l;
         word_t dd;
         word_t e;
         dd = obs_data.pop_front();
         t  = obs_tid.pop_front();
         l  = obs_last.pop_front();
         e  = (exp_q[exp_tid].size() > 0) ? exp_q[exp_tid].pop_front() : ~dd;
         nwords++;
         checks++;
         if (t !== exp_tid || l !== (exp_tid == N - 1) || dd !== e) begin
            failures++;
            $display("FAIL bp_word got=tid%0d l%b d%h exp=tid%0d l%b d%h", t, l, dd,
                     exp_tid, (exp_tid == N - 1), e);
         end
         exp_tid = (exp_tid + 1) % N;
      end
      checks++;
      if (nwords !== 4 || bus.m_axis_tvalid !== 1'b0) begin
         failures++;
         $display("FAIL bp_count got=%0d words valid %b exp=4 words valid 0", nwords,
                  bus.m_axis_tvalid);
      end
   endtask

   task automatic test_random();
      logic [N-1:0] vld    = '0;
      int           frames = 0;
      int           cyc    = 0;
      while (frames < 100 && cyc < 20000) begin
         for (int i = 0; i < N; i++) begin
            if (!vld[i] || acc_last[i]) begin
               vld[i] = ($urandom_range(0, 3) != 0);
               bus.s_axis_tdata[i] = rand_word();
            end
         end
         bus.s_axis_tvalid = vld;
         bus.m_axis_tready = ($urandom_range(0, 3) != 0);
         cycle();
         cyc++;
         while (obs_tid.size() > 0) begin
            int    t;
            bit    l;
            word_t d;
            word_t e;
            d = obs_data.pop_front();
            t = obs_tid.pop_front();
            l = obs_last.pop_front();
            e = (exp_q[exp_tid].size() > 0) ? exp_q[exp_tid].pop_front() : ~d;
            checks++;
            if (t !== exp_tid || l !== (exp_tid == N - 1) || d !== e) begin
               failures++;
               $display("FAIL rand_word got=tid%0d l%b d%h exp=tid%0d l%b d%h", t, l, d,
                        exp_tid, (exp_tid == N - 1), e);
            end
            if (l) frames++;
            exp_tid = (exp_tid + 1) % N;
         end
      end
      bus.s_axis_tvalid = '0;
      bus.m_axis_tready = 1'b1;
      checks++;
      if (frames !== 100) begin
         failures++;
         $display("FAIL rand_frames got=%0d exp=100 (cycles %0d)", frames, cyc);
      end
   endtask

   task automatic test_mid_reset();
      int nwords = 0;
      apply_reset();
      for (int i = 0; i < N; i++) bus.s_axis_tdata[i] = rand_word();
      bus.s_axis_tvalid = '1;
      cycle();
      bus.s_axis_tvalid = '0;
      cycle();
      cycle();
      checks++;
      if (bus.m_axis_tvalid !== 1'b1 || bus.m_axis_tid !== TIDW'(1)) begin
         failures++;
         $display("FAIL mrst_pre got=v%b tid%0d exp=v1 tid1", bus.m_axis_tvalid, bus.m_axis_tid);
      end
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if (bus.m_axis_tvalid !== 1'b0 || bus.s_axis_tready !== 4'b1111 || bus.m_axis_tid !== '0) begin
         failures++;
         $display("FAIL mrst_async got=v%b rdy%b tid%0d exp=v0 rdy1111 tid0", bus.m_axis_tvalid,
                  bus.s_axis_tready, bus.m_axis_tid);
      end
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      clear_model();
      for (int i = 0; i < N; i++) bus.s_axis_tdata[i] = rand_word();
      bus.s_axis_tvalid = '1;
      cycle();
      bus.s_axis_tvalid = '0;
      repeat (6) cycle();
      while (obs_tid.size() > 0) begin
         int    t;
         bit    l;
         word_t d;
         word_t e;
         d = obs_data.pop_front();
         t = obs_tid.pop_front();
         l = obs_last.pop_front();
         e = (exp_q[exp_tid].size() > 0) ? exp_q[exp_tid].pop_front() : ~d;
         nwords++;
         checks++;
         if (t !== exp_tid || l !== (exp_tid == N - 1) || d !== e) begin
            failures++;
            $display("FAIL mrst_word got=tid%0d l%b d%h exp=tid%0d l%b d%h", t, l, d,
                     exp_tid, (exp_tid == N - 1), e);
         end
         exp_tid = (exp_tid + 1) % N;
      end
      checks++;
      if (nwords !== 4) begin
         failures++;
         $display("FAIL mrst_count got=%0d exp=4", nwords);
      end
   endtask

   task automatic test_n3();
      word_t d3 [N3];
      for (int f = 0; f < 4; f++) begin
         for (int i = 0; i < N3; i++) begin
            d3[i] = rand_word();
            bus3.s_axis_tdata[i] = d3[i];
         end
         bus3.s_axis_tvalid = '1;
         @(posedge clk);
         #1;
         bus3.s_axis_tvalid = '0;
         for (int j = 0; j < N3; j++) begin
            @(posedge clk);
            #1;
            checks++;
            if (bus3.m_axis_tvalid !== 1'b1 || bus3.m_axis_tid !== TIDW'(j) ||
                bus3.m_axis_tdata !== d3[j] || bus3.m_axis_tlast !== (j == N3 - 1)) begin
               failures++;
               $display("FAIL n3_f%0d_w%0d got=v%b tid%0d d%h l%b exp=v1 tid%0d d%h l%b", f, j,
                        bus3.m_axis_tvalid, bus3.m_axis_tid, bus3.m_axis_tdata,
                        bus3.m_axis_tlast, j, d3[j], (j == N3 - 1));
            end
         end
         @(posedge clk);
         #1;
         checks++;
         if (bus3.m_axis_tvalid !== 1'b0 || bus3.s_axis_tready !== 3'b111) begin
            failures++;
            $display("FAIL n3_f%0d_end got=v%b rdy%b exp=v0 rdy111", f, bus3.m_axis_tvalid,
                     bus3.s_axis_tready);
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_out_of_order();
      test_backpressure();
      test_random();
      test_mid_reset();
      test_n3();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog got=timeout exp=completion");
      $fatal(1, "watchdog expired");
   end

endmodule
